cordic_prerotate: RTL and testbench
===================================

# cordic_prerotate

Input stage of the CORDIC pipeline, directly upstream of the first iteration unit. Folds each operand into the CORDIC convergence range by an exact ±90° pre-rotation and adjusts the angle accumulator to match. It registers the result behind a valid/ready handshake, with a two-entry skid buffer so that full throughput is kept under back-pressure. It also emits the applied fold as a sideband for the output post-processor.

## Interface
- `DATA_OP_WIDTH`, default 18: width W of x, y and z, all signed two's complement.
- `FUNC_WIDTH`, default 1: width of the function select. Value 0 is rotation; value 1 is vectoring.
- `i_clk`, input, 1: clock. All logic is rising-edge.
- `i_rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `i_valid`, input, 1: upstream operand valid.
- `o_ready`, output, 1: block can accept an operand.
- `i_func`, input, FUNC_WIDTH: function select for this operand.
- `i_x`, `i_y`, input, W each: input vector.
- `i_z`, input, W: binary angle. The range [-π, π) maps to [-2^(W-1), 2^(W-1)), so π/2 = 2^(W-2).
- `o_valid`, output, 1: output operand valid.
- `i_ready`, input, 1: downstream accepts.
- `o_func`, output, FUNC_WIDTH: function select, passed through.
- `o_x`, `o_y`, `o_z`, output, W each: folded operand.
- `o_quad`, output, 2: fold applied. 00 = none; 01 = rotated +90°; 10 = rotated −90°; 11 is never produced.

## Operation
- Transfer in happens when `i_valid && o_ready`. Transfer out happens when `o_valid && i_ready`.
- Let H = 2^(W-2).
- Rotation mode (`i_func == 0`):
  - `i_z >= H`: x' = −y, y' = x, z' = z − H, quad = 01.
  - `i_z < −H`: x' = y, y' = −x, z' = z + H, quad = 10.
  - Otherwise the operand passes unchanged with quad = 00.
- Vectoring mode (`i_func != 0`):
  - `i_x < 0` and `i_y >= 0`: x' = y, y' = −x, z' = z + H, quad = 10.
  - `i_x < 0` and `i_y < 0`: x' = −y, y' = x, z' = z − H, quad = 01.
  - `i_x >= 0`: the operand passes unchanged with quad = 00.
- Negation of x or y saturates: −(−2^(W-1)) = 2^(W-1) − 1. Nothing else saturates.
- z add/subtract is modulo 2^W, which is a natural binary-angle wrap.
- Datapath is a main register M and a skid register S, each with its own valid bit.
  - Outputs are always driven from M. `o_valid` = M.valid.
  - `o_ready` = !S.valid, taken from a flop with no combinational path from `i_ready`.
- Per-cycle update rules:
  - If M is empty or M is transferring out: M loads S if S.valid; otherwise M loads the folded input if there is a transfer in. When S is drained into M, S.valid clears.
  - If M holds and does not transfer out, and a transfer in occurs: the folded input loads into S and S.valid sets.
  - A simultaneous transfer in and transfer out with S empty passes the new operand straight into M. Throughput stays at one per cycle.
- Operand order is strictly preserved. No operand is dropped or duplicated.

## Timing
- Latency from transfer in to `o_valid` is 1 cycle when M is empty or draining.
- Throughput is 1 operand per cycle while `i_ready` stays high.
- Reset (`i_rst_n` low at a clock edge):
  - M.valid and S.valid become 0.
  - `o_valid` = 0 and `o_ready` = 0 while reset is held.
  - `o_x`, `o_y`, `o_z`, `o_func` and `o_quad` all reset to 0.
  - `o_ready` rises on the first edge after release.
- Reset during any state, including full, discards M and S contents. No transfer completes in the reset cycle.
- Once `o_valid` is high, all outputs are stable until a transfer out.
- With `i_ready` low: the first operand is held in M and the second goes to S. `o_ready` then drops on the next edge, and further `i_valid` is ignored.

## Test plan
- Rotation, W=18, x=1000, y=0, z=100000 → one cycle later o_x=0, o_y=1000, o_z=34464, o_quad=01.
- Rotation, x=1000, y=0, z=−131072 → o_x=0, o_y=−1000, o_z=−65536, o_quad=10. Also z=65535 → unchanged, o_quad=00.
- Vectoring, x=−500, y=200, z=0 → o_x=200, o_y=500, o_z=65536, o_quad=10. Also x=−500, y=−200 → o_x=200, o_y=−500, o_z=−65536, o_quad=01.
- Saturation, rotation, x=5, y=−131072, z=70000 → o_x=131071, o_y=5, o_z=4464.
- Back-pressure: stream 8 operands with `i_valid` always high. Hold `i_ready` low for cycles 3–6. Check `o_ready` drops after 2 buffered operands, all 8 arrive in order with none lost or duplicated, and throughput returns to 1 per cycle.
- Reset mid-stream: with M and S full, pulse `i_rst_n` low for 1 cycle. Check `o_valid`=0, all outputs 0, `o_ready` rises on the next edge, and no stale operand appears afterwards.

Source files
------------

// File: rtl/cordic_prerotate.sv
// CORDIC input stage: exact +/-90 degree pre-rotation into the convergence range,
// registered behind a valid/ready handshake with a two-entry skid buffer.
module cordic_prerotate #(
    parameter int unsigned DATA_OP_WIDTH = 18,
    parameter int unsigned FUNC_WIDTH    = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [FUNC_WIDTH-1:0]           i_func,
    input  logic signed [DATA_OP_WIDTH-1:0] i_x,
    input  logic signed [DATA_OP_WIDTH-1:0] i_y,
    input  logic signed [DATA_OP_WIDTH-1:0] i_z,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [FUNC_WIDTH-1:0]           o_func,
    output logic signed [DATA_OP_WIDTH-1:0] o_x,
    output logic signed [DATA_OP_WIDTH-1:0] o_y,
    output logic signed [DATA_OP_WIDTH-1:0] o_z,
    output logic [1:0]                      o_quad
);

    localparam int unsigned W = DATA_OP_WIDTH;
    localparam logic signed [W-1:0] HALF     = {2'b01, {(W-2){1'b0}}};
    localparam logic signed [W-1:0] NEG_HALF = {2'b11, {(W-2){1'b0}}};
    localparam logic signed [W-1:0] MIN_VAL  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_VAL  = {1'b0, {(W-1){1'b1}}};

    localparam logic [1:0] QUAD_NONE = 2'b00;
    localparam logic [1:0] QUAD_POS  = 2'b01;
    localparam logic [1:0] QUAD_NEG  = 2'b10;

    // Negation that maps the most negative code to the most positive one
    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] v);
        return (v == MIN_VAL) ? MAX_VAL : W'(-v);
    endfunction

    logic signed [W-1:0]   fold_x_c, fold_y_c, fold_z_c;
    logic [1:0]            fold_quad_c;
    logic                  rot_pos_c, rot_neg_c;

    logic                  m_valid, s_valid, ready_q;
    logic signed [W-1:0]   m_x, m_y, m_z, s_x, s_y, s_z;
    logic [FUNC_WIDTH-1:0] m_func, s_func;
    logic [1:0]            m_quad, s_quad;

    logic                  xfer_in_c, m_free_c, s_valid_nxt_c;

    // Fold decision and the folded operand
    always_comb begin
        rot_pos_c = 1'b0;
        rot_neg_c = 1'b0;
        if (i_func == '0) begin
            if (i_z >= HALF)          rot_pos_c = 1'b1;
            else if (i_z < NEG_HALF)  rot_neg_c = 1'b1;
        end else if (i_x[W-1]) begin
            if (i_y[W-1]) rot_pos_c = 1'b1;
            else          rot_neg_c = 1'b1;
        end

        fold_x_c    = i_x;
        fold_y_c    = i_y;
        fold_z_c    = i_z;
        fold_quad_c = QUAD_NONE;
        if (rot_pos_c) begin
            fold_x_c    = sat_neg(i_y);
            fold_y_c    = i_x;
            fold_z_c    = W'(i_z - HALF);
            fold_quad_c = QUAD_POS;
        end else if (rot_neg_c) begin
            fold_x_c    = i_y;
            fold_y_c    = sat_neg(i_x);
            fold_z_c    = W'(i_z + HALF);
            fold_quad_c = QUAD_NEG;
        end
    end

    // Handshake qualifiers; ready is a flop so i_ready never reaches o_ready combinationally
    always_comb begin
        xfer_in_c     = i_valid && ready_q;
        m_free_c      = !m_valid || i_ready;
        s_valid_nxt_c = !m_free_c && (s_valid || xfer_in_c);
    end

    // Main and skid registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            ready_q <= 1'b0;
            m_x     <= '0;
            m_y     <= '0;
            m_z     <= '0;
            m_func  <= '0;
            m_quad  <= '0;
            s_x     <= '0;
            s_y     <= '0;
            s_z     <= '0;
            s_func  <= '0;
            s_quad  <= '0;
        end else begin
            ready_q <= !s_valid_nxt_c;
            s_valid <= s_valid_nxt_c;
            if (m_free_c) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_x     <= s_x;
                    m_y     <= s_y;
                    m_z     <= s_z;
                    m_func  <= s_func;
                    m_quad  <= s_quad;
                end else begin
                    m_valid <= xfer_in_c;
                    if (xfer_in_c) begin
                        m_x    <= fold_x_c;
                        m_y    <= fold_y_c;
                        m_z    <= fold_z_c;
                        m_func <= i_func;
                        m_quad <= fold_quad_c;
                    end
                end
            end else if (xfer_in_c) begin
                s_x    <= fold_x_c;
                s_y    <= fold_y_c;
                s_z    <= fold_z_c;
                s_func <= i_func;
                s_quad <= fold_quad_c;
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = m_valid;
    assign o_x     = m_x;
    assign o_y     = m_y;
    assign o_z     = m_z;
    assign o_func  = m_func;
    assign o_quad  = m_quad;

endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed self-checking bench for cordic_prerotate (W=18): fold cases,
// saturation, z wrap, back-pressure streaming and mid-stream reset.
module tb_cordic_prerotate;

    localparam int unsigned W = 18;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid, in_ready_up, out_valid, out_ready;
    logic [0:0]          in_func, out_func;
    logic signed [W-1:0] in_x, in_y, in_z, out_x, out_y, out_z;
    logic [1:0]          out_quad;

    int errors = 0;
    int checks = 0;

    cordic_prerotate #(.DATA_OP_WIDTH(W), .FUNC_WIDTH(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready_up),
        .i_func  (in_func),
        .i_x     (in_x),
        .i_y     (in_y),
        .i_z     (in_z),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_func  (out_func),
        .o_x     (out_x),
        .o_y     (out_y),
        .o_z     (out_z),
        .o_quad  (out_quad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand with downstream ready, check the registered result and its drain
    task automatic send_one(input string tag, input logic f, input int x, input int y, input int z,
                            input int ex, input int ey, input int ez, input int eq);
        in_valid = 1'b1;
        in_func  = f;
        in_x     = W'(x);
        in_y     = W'(y);
        in_z     = W'(z);
        tick();
        in_valid = 1'b0;
        check({tag, ".valid"}, 32'(out_valid), 1);
        check({tag, ".x"}, out_x, ex);
        check({tag, ".y"}, out_y, ey);
        check({tag, ".z"}, out_z, ez);
        check({tag, ".quad"}, 32'(out_quad), eq);
        check({tag, ".func"}, 32'(out_func), 32'(f));
        tick();
        check({tag, ".drain"}, 32'(out_valid), 0);
    endtask

    int sent, recv, cnt, last_out_cyc;
    logic exp_ready, acc, outx;
    int ex, ey, ez, eq;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_func   = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst.valid", 32'(out_valid), 0);
        check("rst.ready", 32'(in_ready_up), 0);
        check("rst.x", out_x, 0);
        check("rst.quad", 32'(out_quad), 0);
        rst_n = 1'b1;
        tick();
        check("rel.ready", 32'(in_ready_up), 1);
        check("rel.valid", 32'(out_valid), 0);

        send_one("rot_pos",   1'b0, 1000, 0, 100000,   0, 1000, 34464, 1);
        send_one("rot_neg",   1'b0, 1000, 0, -131072,  0, -1000, -65536, 2);
        send_one("rot_none",  1'b0, 1000, 0, 65535,    1000, 0, 65535, 0);
        send_one("rot_edge",  1'b0, 1000, 7, -65536,   1000, 7, -65536, 0);
        send_one("vec_neg",   1'b1, -500, 200, 0,      200, 500, 65536, 2);
        send_one("vec_pos",   1'b1, -500, -200, 0,     200, -500, -65536, 1);
        send_one("vec_none",  1'b1, 0, -5, 7,          0, -5, 7, 0);
        send_one("sat",       1'b0, 5, -131072, 70000, 131071, 5, 4464, 1);
        send_one("zwrap",     1'b1, -1, 0, 131071,     0, 1, -65537, 2);

        // Stream of 8 with downstream stalled in cycles 3..6
        sent = 0;
        recv = 0;
        cnt = 0;
        last_out_cyc = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            in_func   = 1'b0;
            in_x      = W'(100 + sent);
            in_y      = W'(10 * sent + 1);
            in_z      = W'((sent % 2 == 1) ? 70000 : sent);
            exp_ready = (cnt < 2);
            check("bp.ready", 32'(in_ready_up), 32'(exp_ready));
            check("bp.valid", 32'(out_valid), 32'(cnt > 0));
            acc  = in_valid && exp_ready;
            outx = (cnt > 0) && out_ready;
            if (outx) begin
                if (recv % 2 == 1) begin
                    ex = -(10 * recv + 1); ey = 100 + recv; ez = 4464; eq = 1;
                end else begin
                    ex = 100 + recv; ey = 10 * recv + 1; ez = recv; eq = 0;
                end
                check("bp.x", out_x, ex);
                check("bp.y", out_y, ey);
                check("bp.z", out_z, ez);
                check("bp.quad", 32'(out_quad), eq);
                recv++;
                last_out_cyc = cyc;
            end
            tick();
            if (acc) sent++;
            cnt = cnt + (acc ? 1 : 0) - (outx ? 1 : 0);
        end
        in_valid = 1'b0;
        check("bp.recv", recv, 8);
        check("bp.last_cycle", last_out_cyc, 12);

        // Fill M and S, then reset for one cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_func   = 1'b1;
        in_x      = W'(-300);
        in_y      = W'(40);
        in_z      = W'(9);
        tick();
        tick();
        tick();
        check("full.ready", 32'(in_ready_up), 0);
        check("full.valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        tick();
        check("mrst.valid", 32'(out_valid), 0);
        check("mrst.ready", 32'(in_ready_up), 0);
        check("mrst.x", out_x, 0);
        check("mrst.y", out_y, 0);
        check("mrst.z", out_z, 0);
        check("mrst.func", 32'(out_func), 0);
        check("mrst.quad", 32'(out_quad), 0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mrel.ready", 32'(in_ready_up), 1);
        check("mrel.valid", 32'(out_valid), 0);
        tick();
        tick();
        check("mrel.stale", 32'(out_valid), 0);
        send_one("post_rst", 1'b0, 11, 22, 33, 11, 22, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
